// File: rtl/corner_adjust_pkg.sv
// corner_adjust_pkg: shared state/direction enums and saturating step helper
package corner_adjust_pkg;
    typedef enum logic {TRACK, MANUAL} state_t;
    typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
    function automatic logic [31:0] sat_step(
        input logic [31:0] value,
        input logic        delta_sign,
        input logic [31:0] step,
        input logic [31:0] max
    );
        logic [32:0] r;
        r = delta_sign ? (value < step ? 33'd0 : {1'b0, value - step})
                       : {1'b0, value} + {1'b0, step};
        return r > {1'b0, max} ? max : r[31:0];
    endfunction
endpackage

// File: rtl/key_repeat.sv
// key_repeat: direction level + rearm in, one-cycle step strobe out with hold-to-repeat
module key_repeat
    import corner_adjust_pkg::*;
#(
    parameter logic [31:0] REPEAT_DELAY = 32'd25_000_000,
    parameter logic [31:0] REPEAT_RATE  = 32'd3_250_000
) (
    input  logic clk,
    input  logic rst,
    input  dir_t dir,
    input  logic rearm,
    output logic step
);
    localparam logic [31:0] MX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW = $clog2({1'b0, MX} + 33'd1);
    localparam logic [CW-1:0] DLY = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RATE = CW'(REPEAT_RATE);
    dir_t prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic rep_q, rep_d;
    always_comb begin
        prev_d = dir;
        step = 1'b0;
        cnt_d = '0;
        rep_d = 1'b0;
        if (dir != DIR_NONE && (dir != prev_q || rearm)) begin
            step = 1'b1;
            cnt_d = CW'(1);
        end else if (dir != DIR_NONE) begin
            step = cnt_q == (rep_q ? RATE : DLY);
            cnt_d = step ? CW'(1) : cnt_q + CW'(1);
            rep_d = rep_q | step;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= DIR_NONE;
            cnt_q <= '0;
            rep_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            cnt_q <= cnt_d;
            rep_q <= rep_d;
        end
    end
endmodule

// File: rtl/corner_adjust.sv
// corner_adjust: track/manual corner override; buttons+sel+raw corners in, registered x/y, manual, step_pulse out
module corner_adjust
    import corner_adjust_pkg::*;
#(
    parameter int NUM_CORNERS = 4,
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 9,
    parameter int X_MAX = 639,
    parameter int Y_MAX = 479,
    parameter int STEP = 8,
    parameter logic [31:0] REPEAT_DELAY = 32'd25_000_000,
    parameter logic [31:0] REPEAT_RATE = 32'd3_250_000,
    localparam int SEL_W = NUM_CORNERS > 2 ? $clog2(NUM_CORNERS) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic up,
    input  logic down,
    input  logic left,
    input  logic right,
    input  logic override,
    input  logic [SEL_W-1:0] sel,
    input  logic [NUM_CORNERS*X_WIDTH-1:0] x_raw,
    input  logic [NUM_CORNERS*Y_WIDTH-1:0] y_raw,
    output logic [NUM_CORNERS*X_WIDTH-1:0] x,
    output logic [NUM_CORNERS*Y_WIDTH-1:0] y,
    output logic manual,
    output logic step_pulse
);
    state_t state_q, state_d;
    logic [NUM_CORNERS*X_WIDTH-1:0] x_q, x_d;
    logic [NUM_CORNERS*Y_WIDTH-1:0] y_q, y_d;
    logic [SEL_W-1:0] sel_q;
    logic pulse_q, pulse_d, step, sel_ok;
    logic [31:0] xs, ys;
    dir_t dir;
    assign dir = !(state_q == MANUAL && override) ? DIR_NONE :
                 down ? DIR_DOWN : up ? DIR_UP : left ? DIR_LEFT : right ? DIR_RIGHT : DIR_NONE;
    assign sel_ok = int'(sel) < NUM_CORNERS;
    key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rep (
        .clk(clk), .rst(rst), .dir(dir), .rearm(sel != sel_q), .step(step)
    );
    always_comb begin
        state_d = override ? MANUAL : TRACK;
        x_d = x_q;
        y_d = y_q;
        pulse_d = 1'b0;
        xs = '0;
        ys = '0;
        if (state_q == TRACK || !override) begin
            x_d = x_raw;
            y_d = y_raw;
        end else if (step && sel_ok) begin
            pulse_d = 1'b1;
            for (int i = 0; i < NUM_CORNERS; i++) begin
                if (int'(sel) == i) begin
                    xs = sat_step(32'(x_q[i*X_WIDTH +: X_WIDTH]), dir == DIR_LEFT, STEP, X_MAX);
                    ys = sat_step(32'(y_q[i*Y_WIDTH +: Y_WIDTH]), dir == DIR_UP, STEP, Y_MAX);
                    if (dir == DIR_LEFT || dir == DIR_RIGHT) x_d[i*X_WIDTH +: X_WIDTH] = xs[X_WIDTH-1:0];
                    else y_d[i*Y_WIDTH +: Y_WIDTH] = ys[Y_WIDTH-1:0];
                end
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TRACK;
            x_q <= '0;
            y_q <= '0;
            sel_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q <= x_d;
            y_q <= y_d;
            sel_q <= sel;
            pulse_q <= pulse_d;
        end
    end
    assign x = x_q;
    assign y = y_q;
    assign manual = state_q == MANUAL;
    assign step_pulse = pulse_q;
endmodule

// File: tb/tb_corner_adjust.sv
// tb_corner_adjust: directed scoreboard bench for corner_adjust
module tb_corner_adjust;
    import corner_adjust_pkg::*;
    logic clk = 1'b0, rst = 1'b1;
    logic up = 0, down = 0, left = 0, right = 0, override = 0;
    logic [1:0] sel = '0;
    logic [39:0] x_raw, x;
    logic [35:0] y_raw, y;
    logic manual, step_pulse;
    int checks = 0, errors = 0;
    typedef struct {
        string tag;
        int c;
        int ex;
        int ey;
        bit em;
        bit ep;
    } exp_t;
    exp_t sb[$];
    corner_adjust #(.REPEAT_DELAY(32'd4), .REPEAT_RATE(32'd2)) dut (
        .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
        .override(override), .sel(sel), .x_raw(x_raw), .y_raw(y_raw),
        .x(x), .y(y), .manual(manual), .step_pulse(step_pulse)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask
    task automatic push(input string tag, input int c, input int ex, input int ey, input bit em, input bit ep);
        exp_t e;
        e.tag = tag; e.c = c; e.ex = ex; e.ey = ey; e.em = em; e.ep = ep;
        sb.push_back(e);
    endtask
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".x"}, int'(x[e.c*10 +: 10]), e.ex);
            chk({e.tag, ".y"}, int'(y[e.c*9 +: 9]), e.ey);
            chk({e.tag, ".manual"}, int'(manual), int'(e.em));
            chk({e.tag, ".pulse"}, int'(step_pulse), int'(e.ep));
        end
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, ".x_all"}, int'(x == '0), 1);
        chk({tag, ".y_all"}, int'(y == '0), 1);
        chk({tag, ".manual"}, int'(manual), 0);
        chk({tag, ".pulse"}, int'(step_pulse), 0);
    endtask
    initial begin
        int n, ex;
        x_raw = {10'd3, 10'd600, 10'd200, 10'd100};
        y_raw = {9'd5, 9'd200, 9'd100, 9'd50};
        #3;
        chk_zero("reset");
        @(posedge clk);
        #1 rst = 0;
        push("track", 0, 100, 50, 0, 0); tick();
        override = 1; down = 1;
        push("entry", 0, 100, 50, 1, 0); tick();
        push("first_down", 0, 100, 58, 1, 1); tick();
        down = 0;
        push("release", 0, 100, 58, 1, 0); tick();
        sel = 2; right = 1; n = 0;
        for (int c = 0; c <= 12; c++) begin
            bit p;
            p = c == 0 || (c >= 4 && c % 2 == 0);
            if (p) n++;
            ex = 600 + 8 * n > 639 ? 639 : 600 + 8 * n;
            push($sformatf("repeat%0d", c), 2, ex, 200, 1, p); tick();
        end
        right = 0;
        push("repeat_rel", 2, 639, 200, 1, 0); tick();
        sel = 1; left = 1;
        push("left_s1", 1, 192, 100, 1, 1); tick();
        push("left_s1_hold", 1, 192, 100, 1, 0); tick();
        sel = 3;
        push("sel_switch", 3, 0, 5, 1, 1);
        push("sel_old", 1, 192, 100, 1, 1); tick();
        push("sel_hold_a", 1, 192, 100, 1, 0); tick();
        push("sel_hold_b", 1, 192, 100, 1, 0); tick();
        left = 0;
        push("left_rel", 3, 0, 5, 1, 0); tick();
        up = 1;
        push("up_clamp", 3, 0, 0, 1, 1); tick();
        up = 0; sel = 0;
        push("up_rel", 3, 0, 0, 1, 0); tick();
        up = 1; down = 1;
        push("prio_down", 0, 100, 66, 1, 1); tick();
        up = 0; down = 0;
        push("prio_rel", 0, 100, 66, 1, 0); tick();
        down = 1;
        push("pre_exit", 0, 100, 74, 1, 1); tick();
        override = 0;
        push("exit", 0, 100, 50, 0, 0); tick();
        push("exit_hold", 0, 100, 50, 0, 0); tick();
        override = 1;
        push("reentry", 0, 100, 50, 1, 0); tick();
        push("re_down", 0, 100, 58, 1, 1); tick();
        push("re_hold", 0, 100, 58, 1, 0); tick();
        rst = 1;
        #2;
        chk_zero("mid_rst");
        override = 0; down = 0;
        @(posedge clk);
        #1 rst = 0;
        push("post_rst", 0, 100, 50, 0, 0); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/corner_adjust.md
# corner_adjust

Parametrised manual override for the projector-correction corner points. Sits between the corner-detection output and the perspective-transform stage. In track mode it forwards detected corners. In override mode it lets the user nudge any selected corner with the direction buttons, using saturating steps and hold-to-repeat.

## Interface
- `NUM_CORNERS`, default 4: number of corner points; must be ≥ 2.
- `X_WIDTH`, default 10: x coordinate width.
- `Y_WIDTH`, default 9: y coordinate width.
- `X_MAX`, default 639: largest legal x.
- `Y_MAX`, default 479: largest legal y.
- `STEP`, default 8: pixels moved per step; must be ≥ 1.
- `REPEAT_DELAY`, default 32'd25_000_000: cycles a button is held before auto-repeat starts; must be ≥ 1.
- `REPEAT_RATE`, default 32'd3_250_000: cycles between auto-repeat steps; must be ≥ 1.
- `clk`, input, 1: sole clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `up`, `down`, `left`, `right`, input, 1 each: debounced, synchronised button levels.
- `override`, input, 1: 1 = manual mode, 0 = track mode.
- `sel`, input, `SEL_W` = max(1, $clog2(NUM_CORNERS)): index of the corner being edited.
- `x_raw`, input, `NUM_CORNERS*X_WIDTH`: detected x coordinates, corner i at `[i*X_WIDTH +: X_WIDTH]`.
- `y_raw`, input, `NUM_CORNERS*Y_WIDTH`: detected y coordinates, packed the same way.
- `x`, output, `NUM_CORNERS*X_WIDTH`: corrected x coordinates.
- `y`, output, `NUM_CORNERS*Y_WIDTH`: corrected y coordinates.
- `manual`, output, 1: 1 while in MANUAL state.
- `step_pulse`, output, 1: one-cycle strobe on every applied step.

## Operation
- State machine with two states:
  - TRACK: every clock, `x <= x_raw` and `y <= y_raw`.
  - TRACK → MANUAL when `override` = 1. On that transition cycle, all corners load from raw once and no step is applied, even if a button is already high.
  - MANUAL: raw inputs are ignored; only corner `sel` can change.
  - MANUAL → TRACK when `override` = 0. That cycle already loads raw.
- Direction select: one direction is active at a time, with priority down > up > left > right (same priority as the existing manual UI).
- Step generation is handled by the `key_repeat` sub-module:
  - One step on the first MANUAL cycle where the active direction rises or changes.
  - If the same direction is held, another step after `REPEAT_DELAY` cycles, then one every `REPEAT_RATE` cycles.
  - Releasing all buttons, changing direction, or changing `sel` re-arms the sequence. Changing direction or `sel` while a button is held counts as a new press.
- Arithmetic is saturating and clamps to the limit rather than stopping short:
  - down: y = min(y+STEP, Y_MAX)
  - up: y = max(y−STEP, 0)
  - right: x = min(x+STEP, X_MAX)
  - left: x = max(x−STEP, 0)
  - Compute with one guard bit so there is no wrap.
- Out-of-range raw values (for example x_raw > X_MAX) are passed through unchanged. The first step on that corner clamps it.
- `sel` ≥ NUM_CORNERS: no corner changes and `step_pulse` stays 0.

## Timing
- Reset values:
  - `x`, `y`: all zero.
  - `manual`: 0; `step_pulse`: 0.
  - State: TRACK.
  - Repeat counter: 0; previous-direction register: none.
- All outputs are registered:
  - TRACK: `x`/`y` follow raw with 1-cycle latency.
  - Mode change: takes effect on the `clk` edge that samples the new `override` value; `manual` updates on the same edge.
- First press: a button sampled high at edge N (in MANUAL, not the entry cycle) updates the coordinate and asserts `step_pulse` at edge N.
- Held button:
  - Next step at edge N+REPEAT_DELAY.
  - Following steps at N+REPEAT_DELAY+k·REPEAT_RATE.
- Repeat counter width is $clog2(max(REPEAT_DELAY, REPEAT_RATE)+1). It stays at 0 when idle.
- Reset asserted mid-hold or mid-MANUAL: immediate return to reset values. After release, the block starts in TRACK.

## Structure
- Package `corner_adjust_pkg` holds:
  - The state enum {TRACK, MANUAL}.
  - The direction enum {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT}.
  - Function `sat_step(value, delta_sign, step, max)`.
- Sub-module `key_repeat`: direction level plus re-arm input in, one-cycle step strobe out, parameters `REPEAT_DELAY` and `REPEAT_RATE`. The top level handles the FSM, corner muxing and arithmetic.

## Test plan
- Reset, then TRACK with `x_raw`[0] = 100 and `y_raw`[0] = 50 → after one cycle, `x`[0] = 100, `y`[0] = 50 and `manual` = 0.
- Raise `override` with `down` already high, corner 0 at (100, 50):
  - Entry cycle: corner 0 stays (100, 50) and no `step_pulse`.
  - Next cycle: y[0] = 58 and `step_pulse` = 1.
- With REPEAT_DELAY = 4, REPEAT_RATE = 2, hold `right` on `sel` = 2 starting at x = 600:
  - Steps at cycles 0, 4, 6, 8, 10 → x = 608, 616, 624, 632, 639.
  - Then held at 639 (clamped), while `step_pulse` still pulses.
- `up` on a corner at y = 5 → y = 0. `left` on a corner at x = 3 → x = 0.
- Hold `left` and switch `sel` from 1 to 3 mid-hold → corner 3 steps immediately and corner 1 does not change afterwards.
- Drop `override` while `down` is held → the next cycle loads raw values and no further steps occur. Asserting `rst` mid-hold → all outputs read zero on the same cycle.
